serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// FSM state encoding, default operand width and counter sizing.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter wide enough to hold 0..w without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = x - y - b_in, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes x - y - b_in one bit per clock, LSB first,
// through a single time-multiplexed full_subtractor.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready=1, waiting for start; last result held on the outputs
// ST_RUN  | one bit processed per edge, WIDTH edges in total
// ST_DONE | done=1 for one cycle with diff/b_out/v valid
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             v,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_b;

  full_subtractor u_fs (
    .x     (x_sh[0]),
    .y     (y_sh[0]),
    .b_in  (borrow),
    .diff  (bit_d),
    .b_out (bit_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      x_sh   <= '0;
      y_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      ready  <= 1'b1;
      diff   <= '0;
      b_out  <= 1'b0;
      v      <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sh   <= x;
            y_sh   <= y;
            borrow <= b_in;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Operands shift right so the current bit is always at index 0.
          diff   <= {bit_d, diff[WIDTH-1:1]};
          x_sh   <= x_sh >> 1;
          y_sh   <= y_sh >> 1;
          borrow <= bit_b;
          if (cnt == LAST_BIT) begin
            // borrow here is the borrow into the MSB.
            b_out <= bit_b;
            v     <= borrow ^ bit_b;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
